// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D line-fill arbiter: FSM states, grant encoding and the
// default cache-line width.
package mem_arb_pkg;

    localparam int LINE_W_DEFAULT = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way tie-break between the I and D requesters: a lone requester always wins;
// on a tie D wins when prioritised, otherwise the side that did not win last time.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  gnt_t last_grant,
    input  logic prio_d,
    output gnt_t grant
);

    always_comb begin
        grant = GNT_I;
        if (req_d && (!req_i || prio_d || last_grant == GNT_I)) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-side line fills and D-side fills/write-backs onto one memory port,
// one transaction at a time, with registered request and response signalling.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_W     = LINE_W_DEFAULT,
    parameter int D_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              I_read,
    input  logic [31:4]       I_addr,
    output logic [LINE_W-1:0] I_rdata,
    output logic              I_ready,
    input  logic              D_read,
    input  logic              D_write,
    input  logic [31:4]       D_addr,
    input  logic [LINE_W-1:0] D_wdata,
    output logic [LINE_W-1:0] D_rdata,
    output logic              D_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:4]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t state_reg;
    gnt_t   last_grant_reg;
    gnt_t   resp_side_reg;
    gnt_t   grant;
    logic   d_req;

    assign d_req = D_read | D_write;

    arb_rr2 u_arb (
        .req_i      (I_read),
        .req_d      (d_req),
        .last_grant (last_grant_reg),
        .prio_d     (D_PRIORITY != 0),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= GNT_I;
            resp_side_reg  <= GNT_I;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            I_ready        <= 1'b0;
            D_ready        <= 1'b0;
            I_rdata        <= '0;
            D_rdata        <= '0;
        end else begin
            I_ready <= 1'b0;
            D_ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (I_read || d_req) begin
                        resp_side_reg <= grant;
                        if (grant == GNT_D) begin
                            state_reg <= BUSY_D;
                            mem_addr  <= D_addr;
                            mem_wdata <= D_wdata;
                            // A simultaneous read+write is treated as a write-back.
                            mem_write <= D_write;
                            mem_read  <= ~D_write;
                        end else begin
                            state_reg <= BUSY_I;
                            mem_addr  <= I_addr;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        I_rdata   <= mem_rdata;
                        I_ready   <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        // Write-back completions leave the last fill line untouched.
                        if (!mem_write) begin
                            D_rdata <= mem_rdata;
                        end
                        D_ready   <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    last_grant_reg <= resp_side_reg;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance and D-priority instance
// driven by the same stimulus so their timing stays in lockstep.
module tb_mem_arbiter;

    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          I_read, D_read, D_write, mem_ready;
    logic [31:4]   I_addr, D_addr;
    logic [LW-1:0] D_wdata, mem_rdata;

    logic [LW-1:0] I_rdata, D_rdata, mem_wdata;
    logic          I_ready, D_ready, mem_read, mem_write;
    logic [31:4]   mem_addr;

    logic [LW-1:0] p_I_rdata, p_D_rdata, p_mem_wdata;
    logic          p_I_ready, p_D_ready, p_mem_read, p_mem_write;
    logic [31:4]   p_mem_addr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [LW-1:0] line_a5, line_wd, line_dead, line_5a, line_k;
    logic [31:4]   exp_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_W(LW), .D_PRIORITY(0)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .I_read(I_read), .I_addr(I_addr), .I_rdata(I_rdata), .I_ready(I_ready),
        .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .D_ready(D_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_arbiter #(.LINE_W(LW), .D_PRIORITY(1)) dut_p (
        .clk(clk), .proc_reset(proc_reset),
        .I_read(I_read), .I_addr(I_addr), .I_rdata(p_I_rdata), .I_ready(p_I_ready),
        .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_rdata(p_D_rdata), .D_ready(p_D_ready),
        .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr),
        .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        line_a5   = {16{8'hA5}};
        line_wd   = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
        line_dead = {4{32'hDEAD_BEEF}};
        line_5a   = {16{8'h5A}};

        proc_reset = 1'b1;
        I_read = 1'b0; D_read = 1'b0; D_write = 1'b0; mem_ready = 1'b0;
        I_addr = '0; D_addr = '0; D_wdata = '0; mem_rdata = '0;
        repeat (3) step();

        // Reset state
        chk("rst_mem_read",  mem_read,  0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_I_ready",   I_ready,   0);
        chk("rst_D_ready",   D_ready,   0);
        chk("rst_I_rdata",   I_rdata,   0);
        chk("rst_D_rdata",   D_rdata,   0);
        proc_reset = 1'b0;

        // I-only fill; I_addr wiggled mid-transaction must not reach mem_addr
        I_read = 1'b1; I_addr = 28'h0000010;
        step();
        chk("i_mem_read",  mem_read,  1);
        chk("i_mem_write", mem_write, 0);
        chk("i_mem_addr",  mem_addr,  28'h0000010);
        I_addr = 28'h00007FF;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("i_busy_addr",  mem_addr, 28'h0000010);
            chk("i_busy_ready", I_ready,  0);
        end
        step();
        mem_ready = 1'b1; mem_rdata = line_a5;
        step();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("i_ready_pulse", I_ready,  1);
        chk("i_rdata",       I_rdata,  line_a5);
        chk("i_mem_read_lo", mem_read, 0);
        chk("i_other_ready", D_ready,  0);
        I_read = 1'b0;
        step();
        chk("i_ready_once", I_ready, 0);

        // D write-back with D_read also high: treated as write
        D_write = 1'b1; D_read = 1'b1; D_addr = 28'h0000020; D_wdata = line_wd;
        step();
        chk("wb_mem_write", mem_write, 1);
        chk("wb_mem_read",  mem_read,  0);
        chk("wb_mem_addr",  mem_addr,  28'h0000020);
        chk("wb_mem_wdata", mem_wdata, line_wd);
        mem_ready = 1'b1; mem_rdata = line_dead;
        step();
        mem_ready = 1'b0;
        chk("wb_D_ready",   D_ready,   1);
        chk("wb_D_rdata",   D_rdata,   0);
        chk("wb_I_ready",   I_ready,   0);
        chk("wb_mem_write_lo", mem_write, 0);
        D_write = 1'b0; D_read = 1'b0;
        step();

        // D fill; I_rdata must keep its last line
        D_read = 1'b1; D_addr = 28'h0000030;
        step();
        chk("df_mem_read", mem_read, 1);
        chk("df_mem_addr", mem_addr, 28'h0000030);
        step();
        mem_ready = 1'b1; mem_rdata = line_5a;
        step();
        mem_ready = 1'b0;
        chk("df_D_ready", D_ready, 1);
        chk("df_D_rdata", D_rdata, line_5a);
        chk("df_I_rdata", I_rdata, line_a5);
        D_read = 1'b0;
        step();
        chk("df_D_ready_once", D_ready, 0);

        // Reset in BUSY_I aborts; a later mem_ready is ignored
        I_read = 1'b1; I_addr = 28'h0000040;
        step();
        chk("ab_mem_read", mem_read, 1);
        step();
        proc_reset = 1'b1;
        step();
        proc_reset = 1'b0; I_read = 1'b0;
        chk("ab_mem_read_lo", mem_read, 0);
        chk("ab_mem_addr",    mem_addr, 0);
        chk("ab_I_ready",     I_ready,  0);
        mem_ready = 1'b1; mem_rdata = line_dead;
        step();
        mem_ready = 1'b0;
        chk("ab_ignored_ready", I_ready,  0);
        chk("ab_ignored_rdata", I_rdata,  0);
        chk("ab_still_idle",    mem_read, 0);
        step();
        chk("ab_no_late_ready", I_ready, 0);

        // Both requesting continuously after reset: D, I, D, I vs. always D
        I_read = 1'b1; I_addr = 28'h0000050;
        D_read = 1'b1; D_addr = 28'h0000060;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 28'h0000060 : 28'h0000050;
            line_k   = {16{8'(8'h10 + k)}};
            step();
            chk("tie_rr_addr",   mem_addr,   exp_addr);
            chk("tie_prio_addr", p_mem_addr, 28'h0000060);
            mem_ready = 1'b1; mem_rdata = line_k;
            step();
            mem_ready = 1'b0;
            chk("tie_rr_D_ready",   D_ready,   (k % 2 == 0) ? 1 : 0);
            chk("tie_rr_I_ready",   I_ready,   (k % 2 == 0) ? 0 : 1);
            chk("tie_prio_D_ready", p_D_ready, 1);
            chk("tie_prio_I_ready", p_I_ready, 0);
            chk("tie_prio_D_rdata", p_D_rdata, line_k);
            step();
            chk("tie_idle_ready", {I_ready, D_ready, p_I_ready, p_D_ready}, 0);
        end
        chk("tie_rr_I_rdata", I_rdata, {16{8'h13}});
        chk("tie_rr_D_rdata", D_rdata, {16{8'h12}});
        chk("tie_prio_I_rdata", p_I_rdata, 0);
        I_read = 1'b0; D_read = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
